fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the fetch/decode stage register.
- Generates sequential fetch addresses from an internal fetch PC and talks to instruction memory over a single-outstanding req/ack handshake.
- Buffers returned words with their next_pc in a small FIFO; the FIFO output drives the F/D register inputs.
- Handles redirects (branch/jump) by flushing the FIFO and discarding any in-flight response.

---
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the fetch/decode register.
// Issues one outstanding request at a time to instruction memory and buffers
// returned words with their next_pc in a small FIFO. Redirects flush the FIFO
// and discard any in-flight response.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_dropped.
//
// imem handshake: imem_req/imem_addr are registered and, once raised, stay
// stable until a cycle with imem_ack=1; imem_req && imem_ack in a cycle means
// the request completes and imem_rdata is valid in that same cycle. Output
// side: an entry transfers when out_valid && out_ready at a clock edge.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_ins,
    output logic [31:0] out_next_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // IDLE: nothing outstanding; REQ: request for fetch_pc outstanding;
    // DROP: request outstanding whose response must be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       fetch_pc;
    logic [31:0]       fetch_pc_next;
    logic [31:0]       addr_next;
    logic [31:0]       target;
    logic [31:0]       seq_pc;

    logic [31:0]       ins_mem [FIFO_DEPTH];
    logic [31:0]       npc_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic              ack_taken;
    logic              push;
    logic              pop;
    logic              has_room;

    // During DROP fetch_pc already holds the redirect target, so it doubles
    // as the latched target for the request issued after the stale ack.
    assign target    = redirect_pc & ~32'h3;
    assign seq_pc    = fetch_pc + 32'd4;
    assign ack_taken = imem_req && imem_ack;
    assign push      = ack_taken && (state == REQ) && !redirect;
    assign pop       = out_valid && out_ready && !redirect;
    assign count_next = redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    assign has_room  = count_next < DEPTH_C;

    // FSM state register plus request address / fetch PC
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_addr <= addr_next;
        end
    end

    // FSM next-state: redirect first, then ack handling, then refill
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (redirect || has_room) state_next = REQ;
            end
            REQ: begin
                if (redirect)      state_next = imem_ack ? REQ : DROP;
                else if (imem_ack) state_next = has_room ? REQ : IDLE;
            end
            DROP: begin
                if (imem_ack) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: request strobe, next fetch PC and next request address
    always_comb begin
        imem_req      = (state != IDLE);
        fetch_pc_next = fetch_pc;
        if (redirect)  fetch_pc_next = target;
        else if (push) fetch_pc_next = seq_pc;
        // A new request (or the held one in REQ, where fetch_pc == imem_addr)
        // always targets fetch_pc; otherwise the address is held.
        addr_next = (state_next == REQ) ? fetch_pc_next : imem_addr;
    end

    // FIFO pointers and occupancy; redirect empties the FIFO
    always_ff @(posedge clk) begin
        if (!reset_n || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    // FIFO storage write: instruction word and its fall-through PC
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            ins_mem[wr_ptr] <= imem_rdata;
            npc_mem[wr_ptr] <= seq_pc;
        end
    end

    assign out_valid   = (count != '0);
    assign out_ins     = out_valid ? ins_mem[rd_ptr] : 32'd0;
    assign out_next_pc = out_valid ? npc_mem[rd_ptr] : 32'd0;

`ifdef FETCH_PERF_CNT_EN
    logic        discard;
    logic [31:0] drop_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // A response is discarded when it lands in DROP or alongside a redirect;
    // a redirect also throws away every buffered entry.
    assign discard  = ack_taken && ((state == DROP) || redirect);
    assign drop_inc = 32'(discard) + (redirect ? 32'(count) : 32'd0);

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, 32'(push));
            perf_dropped <= sat_add(perf_dropped, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit. A transaction-level model
// (expected-entry queue, expected fetch PC, stale-response flag) predicts the
// request strobe, request address and FIFO head every cycle.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;
    localparam int          NPH    = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_ins;
    logic [31:0] out_next_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    // clock
    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_ins     (out_ins),
        .out_next_pc (out_next_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // reference model state: expected FIFO entries {ins, next_pc}
    logic [63:0] exp_q[$];
    logic [63:0] head;
    logic [31:0] exp_pc = 32'd0;
    logic        exp_req = 1'b0;
    logic        stale = 1'b0;
    logic        req_now;
    logic        after_reset = 1'b0;
    logic        model_on = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] exp_fetched = 32'd0;
    logic [31:0] exp_dropped = 32'd0;

    // scoreboard: compare mid-cycle, then advance the model by this cycle's events
    always @(negedge clk) begin
        if (model_on) begin
            check("req", imem_req, exp_req);
            check("addr_lsb", imem_addr & 32'h3, 32'd0);
            if (after_reset) check("rst_addr", imem_addr, RST_PC);
            if (exp_req && !stale) check("addr", imem_addr, exp_pc);
            if (prev_hold) check("addr_hold", imem_addr, prev_addr);
            head = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
            check("valid", out_valid, exp_q.size() != 0);
            check("ins", out_ins, head[63:32]);
            check("next_pc", out_next_pc, head[31:0]);
`ifdef FETCH_PERF_CNT_EN
            check("perf_fetched", perf_fetched, exp_fetched);
            check("perf_dropped", perf_dropped, exp_dropped);
`endif
        end

        prev_hold   = reset_n && model_on && exp_req && !imem_ack;
        prev_addr   = imem_addr;
        after_reset = !reset_n;
        req_now     = exp_req;

        if (!reset_n) begin
            exp_q.delete();
            exp_pc      = RST_PC;
            stale       = 1'b0;
            exp_req     = 1'b0;
            exp_fetched = 32'd0;
            exp_dropped = 32'd0;
            model_on    = 1'b1;
        end else if (model_on) begin
            if (redirect) begin
                exp_dropped = exp_dropped + 32'(exp_q.size());
                if (req_now && imem_ack) exp_dropped = exp_dropped + 32'd1;
                exp_q.delete();
                stale  = req_now && !imem_ack;
                exp_pc = redirect_pc & ~32'h3;
            end else begin
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (req_now && imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                        exp_dropped = exp_dropped + 32'd1;
                    end else begin
                        exp_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
                        exp_pc = exp_pc + 32'd4;
                        exp_fetched = exp_fetched + 32'd1;
                        check("no_overflow", 32'(exp_q.size() <= DEPTH), 32'd1);
                    end
                end
            end
            // a request is pending next cycle if held, restarted by redirect,
            // or a free slot exists
            exp_req = (req_now && !imem_ack) || redirect || (exp_q.size() < DEPTH);
        end
    end

    // phase table: ack %, ready %, redirect %, reset per-mille
    int ack_pct   [NPH] = '{100, 100, 100, 30,  30, 100, 50};
    int rdy_pct   [NPH] = '{100,   0, 100, 70,  50,  50, 50};
    int redir_pct [NPH] = '{  0,   0,   0,  0,  10,  20, 15};
    int rst_pm    [NPH] = '{  0,   0,   0,  0,   0,   0, 20};

    task automatic drive_cycle(input int p);
        @(posedge clk);
        #1;
        reset_n   = !($urandom_range(0, 999) < rst_pm[p]);
        imem_ack  = ($urandom_range(0, 99) < ack_pct[p]);
        out_ready = ($urandom_range(0, 99) < rdy_pct[p]);
        redirect  = ($urandom_range(0, 99) < redir_pct[p]);
        if ($urandom_range(0, 3) == 0)
            redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else
            redirect_pc = $urandom;
        imem_rdata = mem_word(imem_addr);
    endtask

    // driver: reset, then run each phase preceded by a reset pulse
    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        for (int p = 0; p < NPH; p++) begin
            @(posedge clk);
            #1;
            reset_n  = 1'b0;
            imem_ack = 1'b1;
            redirect = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            for (int c = 0; c < 400; c++) drive_cycle(p);
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
